// File: rtl/fp8_sa_pkg.sv
// Shared definitions for the FP8 systolic-array feeder: element width,
// default array dimension and the feeder FSM state type.
package fp8_sa_pkg;
  localparam int FP8_W     = 8;
  localparam int N_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_FLUSH
  } feed_state_e;
endpackage

// File: rtl/skew_delay_line.sv
// Reset-to-zero shift register; output lags input by DEPTH cycles.
module skew_delay_line
  import fp8_sa_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = FP8_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage_reg[k] <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage_reg[k] <= stage_reg[k-1];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/fp8_skew_feeder.sv
// Streams FP8 A/B vectors into a systolic array, skewing lane i by i cycles
// and flushing zeros until the last vector has cleared every lane.
module fp8_skew_feeder
  import fp8_sa_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FP8_W*N-1:0] a_vec,
  input  logic [FP8_W*N-1:0] b_vec,
  output logic [FP8_W*N-1:0] A_bus,
  output logic [FP8_W*N-1:0] B_bus,
  output logic               busy,
  output logic               done
);

  localparam int FLUSH_W = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(N - 2);

  feed_state_e        state_reg, state_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic [FLUSH_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic               done_reg, done_next;
  logic [FP8_W*N-1:0] push_a, push_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      flush_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      flush_cnt_reg <= flush_cnt_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    flush_cnt_next = flush_cnt_reg;
    done_next      = 1'b0;
    in_ready       = 1'b0;
    push_a         = '0;
    push_b         = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_next     = ST_FEED;
            remaining_next = len;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_FEED: begin
        in_ready = 1'b1;
        // A cycle without in_valid leaves the zero bubble in push_a/push_b.
        if (in_valid) begin
          push_a         = a_vec;
          push_b         = b_vec;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_W'(1)) begin
            flush_cnt_next = '0;
            if (N > 1) begin
              state_next = ST_FLUSH;
            end else begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

  // Lane i is delayed i+1 cycles so the array sees a diagonal wavefront.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      skew_delay_line #(.DEPTH(gi + 1), .WIDTH(FP8_W)) u_dl_a (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (push_a[gi*FP8_W +: FP8_W]),
        .dout (A_bus[gi*FP8_W +: FP8_W])
      );
      skew_delay_line #(.DEPTH(gi + 1), .WIDTH(FP8_W)) u_dl_b (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (push_b[gi*FP8_W +: FP8_W]),
        .dout (B_bus[gi*FP8_W +: FP8_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fp8_skew_feeder.sv
// Self-checking bench for fp8_skew_feeder (N=4): directed scenarios plus random
// streams, checked against a cycle-indexed history model of pushed vectors.
module tb_fp8_skew_feeder;
  localparam int N     = 4;
  localparam int LEN_W = 8;
  localparam int W     = 8 * N;
  localparam int VW    = 2 * W + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     a_vec = '0;
  logic [W-1:0]     b_vec = '0;
  logic             in_ready, busy, done;
  logic [W-1:0]     A_bus, B_bus;

  always #5 clk = ~clk;

  fp8_skew_feeder #(.N(N), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_vec   (a_vec),
    .b_vec   (b_vec),
    .A_bus   (A_bus),
    .B_bus   (B_bus),
    .busy    (busy),
    .done    (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: what entered the lanes on each cycle, plus stream-level deadlines.
  int           cyc = 0;
  int           floor_cyc = 0;
  logic [W-1:0] hist_a [4096];
  logic [W-1:0] hist_b [4096];
  bit           m_feed;
  int           m_left, m_idle_from, m_done_at;
  logic [VW-1:0] exp_vec, obs_vec;

  function automatic logic [W-1:0] skewed(input bit is_b, input int t);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = t - 1 - i;
      if (k >= 0 && k >= floor_cyc)
        r[8*i +: 8] = is_b ? hist_b[k % 4096][8*i +: 8] : hist_a[k % 4096][8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_feed = 1'b0; m_left = 0; m_idle_from = 0; m_done_at = -1; floor_cyc = cyc;
  endtask

  // Drive one cycle; leaves observed/expected outputs of that cycle in obs_vec/exp_vec.
  task automatic step(input bit s, input logic [LEN_W-1:0] l, input bit v,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit eb;
    start = s; len = l; in_valid = v; a_vec = a; b_vec = b;
    eb = m_feed || (cyc < m_idle_from);
    exp_vec = {skewed(1'b0, cyc), skewed(1'b1, cyc), eb, m_feed, (cyc == m_done_at)};
    obs_vec = {A_bus, B_bus, busy, in_ready, done};
    hist_a[cyc % 4096] = (m_feed && v) ? a : '0;
    hist_b[cyc % 4096] = (m_feed && v) ? b : '0;
    if (m_feed) begin
      if (v) begin
        m_left--;
        if (m_left == 0) begin
          m_feed = 1'b0; m_idle_from = cyc + N; m_done_at = cyc + N;
        end
      end
    end else if (!eb && s) begin
      if (l != 0) begin m_feed = 1'b1; m_left = int'(l); end
      else m_done_at = cyc + 1;
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic test_reset();
    start = 1'b1; len = 8'd3; in_valid = 1'b1; a_vec = 32'hDEADBEEF; b_vec = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({A_bus, B_bus, busy, in_ready, done} !== '0)
      $display("FAIL reset_low got=%h exp=0", {A_bus, B_bus, busy, in_ready, done});
    else n_pass++;
    rst_n = 1'b1; cyc = 0; model_reset();
    step(1'b0, '0, 1'b1, 32'h01020304, 32'h05060708);
    n_checks++;
    if (obs_vec !== '0) $display("FAIL reset_release got=%h exp=0", obs_vec);
    else n_pass++;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_basic();
    logic [W-1:0] a;
    int s, done_cyc, lane0_hits, lane3_first;
    a = {8'h48, 8'h44, 8'h40, 8'h38};
    s = cyc; done_cyc = -1; lane0_hits = 0; lane3_first = -1;
    step(1'b1, 8'd3, 1'b1, a, 32'h11223344);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1, a, 32'h11223344);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL basic cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
      if (obs_vec[0] && done_cyc < 0) done_cyc = cyc - 1;
      if (obs_vec[W+3 +: 8] == 8'h38) lane0_hits++;
      if (obs_vec[2*W+2 -: 8] == 8'h48 && lane3_first < 0) lane3_first = cyc - 1 - (s + 1);
    end
    n_checks++;
    if (done_cyc - s !== 7) $display("FAIL basic_done_offset got=%0d exp=7", done_cyc - s);
    else n_pass++;
    n_checks++;
    if (lane0_hits !== 3) $display("FAIL basic_lane0_hits got=%0d exp=3", lane0_hits);
    else n_pass++;
    n_checks++;
    if (lane3_first !== 4) $display("FAIL basic_lane3_latency got=%0d exp=4", lane3_first);
    else n_pass++;
    $display("stream len=3 started cyc=%0d done cyc=%0d", s, done_cyc);
  endtask

  task automatic test_len_zero();
    int s, done_cyc, busy_seen;
    s = cyc; done_cyc = -1; busy_seen = 0;
    step(1'b1, 8'd0, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, $urandom, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL len_zero cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
      if (obs_vec[0] && done_cyc < 0) done_cyc = cyc - 1;
      if (obs_vec[2]) busy_seen++;
    end
    n_checks++;
    if (done_cyc - s !== 1 || busy_seen !== 0)
      $display("FAIL len_zero_done got=%0d/%0d exp=1/0", done_cyc - s, busy_seen);
    else n_pass++;
    $display("stream len=0 started cyc=%0d done cyc=%0d", s, done_cyc);
  endtask

  task automatic test_bubble();
    int feed_cycles;
    feed_cycles = 0;
    step(1'b1, 8'd4, 1'b0, '0, '0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0, (i != 1), $urandom | 32'h01010101, $urandom | 32'h01010101);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL bubble cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
      if (obs_vec[1]) feed_cycles++;
    end
    n_checks++;
    if (feed_cycles !== 5) $display("FAIL bubble_feed_len got=%0d exp=5", feed_cycles);
    else n_pass++;
    $display("stream len=4 with bubble, feed cycles=%0d", feed_cycles);
  endtask

  task automatic test_restart_ignored();
    int dones, feed_cycles;
    dones = 0; feed_cycles = 0;
    step(1'b1, 8'd3, 1'b1, $urandom, $urandom);
    for (int i = 0; i < 14; i++) begin
      step((i == 1), 8'd9, 1'b1, $urandom, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL restart cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
      if (obs_vec[0]) dones++;
      if (obs_vec[1]) feed_cycles++;
    end
    n_checks++;
    if (dones !== 1 || feed_cycles !== 3)
      $display("FAIL restart_ignored got=%0d/%0d exp=1/3", dones, feed_cycles);
    else n_pass++;
    $display("stream len=3 with restart attempt, dones=%0d", dones);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'd5, 1'b1, 32'h5A5A5A5A, 32'h3C3C3C3C);
    step(1'b0, '0, 1'b1, 32'h5A5A5A5A, 32'h3C3C3C3C);
    step(1'b0, '0, 1'b1, 32'h5A5A5A5A, 32'h3C3C3C3C);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({A_bus, B_bus, busy, in_ready, done} !== '0)
      $display("FAIL reset_mid_now got=%h exp=0", {A_bus, B_bus, busy, in_ready, done});
    else n_pass++;
    @(posedge clk); cyc++; #1;
    n_checks++;
    if ({A_bus, B_bus, busy, in_ready, done} !== '0)
      $display("FAIL reset_mid_hold got=%h exp=0", {A_bus, B_bus, busy, in_ready, done});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; model_reset();
    step(1'b1, 8'd2, 1'b1, $urandom, $urandom);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1, $urandom, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
    end
    $display("mid-stream reset then stream len=2 at cyc=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    step(1'b1, 8'd3, 1'b1, $urandom, $urandom);
    for (int i = 0; i < 40 && cyc != m_done_at; i++) begin
      step(1'b0, '0, 1'b1, $urandom, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL b2b_first cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (cyc != m_done_at) $display("FAIL b2b_timeout got=%0d exp=%0d", cyc, m_done_at);
    else n_pass++;
    step(1'b1, 8'd2, 1'b1, $urandom, $urandom);
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL b2b_done_cycle got=%h exp=%h", obs_vec, exp_vec);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1, $urandom, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL b2b_second cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
      if (obs_vec[0]) dones++;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL b2b_second_done got=%0d exp=1", dones);
    else n_pass++;
    $display("back-to-back streams len=3,2 finished at cyc=%0d", cyc);
  endtask

  task automatic test_random();
    int streams;
    streams = 0;
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 5) == 0), LEN_W'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), $urandom, $urandom);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL random cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      else n_pass++;
      if (obs_vec[0]) begin
        streams++;
        $display("random stream %0d done at cyc=%0d", streams, cyc - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_bubble();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
